mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: N-port arbiter in front of a single-port RAM.
//   One access at a time: IDLE picks a winner (fixed priority or round-robin),
//   ACCESS holds the latched request on the RAM for RAM_LAT cycles, DONE pulses
//   the winner's done bit. Every output comes straight from a register.
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_req, i_we         per-port request and write enable
//   i_addr, i_wdata     packed per-port address / write data (port i at [i*W +: W])
//   o_gnt, o_done       one-hot grant / completion pulses
//   o_rdata             read data, valid while o_done is high on a read
//   o_busy              high whenever not in IDLE
//   o_ram_addr, o_ram_we, o_ram_wdata, i_ram_rdata  single-port RAM interface
module mem_arbiter #(
  parameter int unsigned N_PORTS = 2,
  parameter int unsigned DW      = 32,
  parameter int unsigned AW      = 16,
  parameter int unsigned RAM_LAT = 1,
  parameter int unsigned RR_MODE = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [N_PORTS-1:0]   i_req,
  input  logic [N_PORTS-1:0]   i_we,
  input  logic [N_PORTS*AW-1:0] i_addr,
  input  logic [N_PORTS*DW-1:0] i_wdata,
  output logic [N_PORTS-1:0]   o_gnt,
  output logic [N_PORTS-1:0]   o_done,
  output logic [DW-1:0]        o_rdata,
  output logic                 o_busy,
  output logic [AW-1:0]        o_ram_addr,
  output logic                 o_ram_we,
  output logic [DW-1:0]        o_ram_wdata,
  input  logic [DW-1:0]        i_ram_rdata
);

  localparam int unsigned PW = $clog2(N_PORTS);
  // RAM_LAT is at most 4, so a 2-bit counter always suffices.
  localparam int unsigned CW = 2;
  localparam logic [CW-1:0] LastCnt = CW'(RAM_LAT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  state_e r_state, w_state_d;

  logic [N_PORTS-1:0] r_gnt, r_done, r_sel;
  logic [DW-1:0]      r_rdata, r_ram_wdata;
  logic [AW-1:0]      r_ram_addr;
  logic               r_ram_we, r_we, r_busy;
  logic [CW-1:0]      r_cnt;
  logic [PW-1:0]      r_ptr;

  logic [N_PORTS-1:0] w_gnt_d, w_done_d, w_sel_d, w_oh;
  logic [DW-1:0]      w_rdata_d, w_ram_wdata_d;
  logic [AW-1:0]      w_ram_addr_d;
  logic               w_ram_we_d, w_we_d, w_found;
  logic [CW-1:0]      w_cnt_d;
  logic [PW-1:0]      w_ptr_d;
  int unsigned        w_idx, w_win;

  // Winner search: starts at 0 (fixed) or at the pointer (round-robin), wrapping upward.
  always_comb begin
    w_found = 1'b0;
    w_win   = 0;
    w_idx   = 0;
    for (int unsigned k = 0; k < N_PORTS; k++) begin
      w_idx = (RR_MODE != 0) ? 32'(r_ptr) + k : k;
      if (w_idx >= N_PORTS) w_idx = w_idx - N_PORTS;
      if (!w_found && (|(i_req & (N_PORTS'(1) << w_idx)))) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
    w_oh = N_PORTS'(1) << w_win;
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_found) w_state_d = StAccess;
      StAccess: if (r_cnt == LastCnt) w_state_d = StDone;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  // Output / datapath next values; registered below so all outputs are flops.
  always_comb begin
    w_gnt_d       = '0;
    w_done_d      = '0;
    w_ram_we_d    = 1'b0;
    w_sel_d       = r_sel;
    w_we_d        = r_we;
    w_ram_addr_d  = r_ram_addr;
    w_ram_wdata_d = r_ram_wdata;
    w_rdata_d     = r_rdata;
    w_cnt_d       = r_cnt;
    w_ptr_d       = r_ptr;
    unique case (r_state)
      StIdle: begin
        if (w_found) begin
          w_gnt_d       = w_oh;
          w_sel_d       = w_oh;
          w_we_d        = |(i_we & w_oh);
          w_ram_we_d    = |(i_we & w_oh);  // write strobe only in the first ACCESS cycle
          w_ram_addr_d  = i_addr[w_win*AW +: AW];
          w_ram_wdata_d = i_wdata[w_win*DW +: DW];
          w_cnt_d       = '0;
          w_ptr_d       = (w_win == N_PORTS - 1) ? '0 : PW'(w_win + 1);
        end
      end
      StAccess: begin
        if (r_cnt == LastCnt) begin
          w_done_d = r_sel;
          w_cnt_d  = '0;
          if (!r_we) w_rdata_d = i_ram_rdata;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
        end
      end
      StDone:  ;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_gnt       <= '0;
      r_done      <= '0;
      r_sel       <= '0;
      r_we        <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rdata     <= '0;
      r_cnt       <= '0;
      r_ptr       <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_gnt       <= w_gnt_d;
      r_done      <= w_done_d;
      r_sel       <= w_sel_d;
      r_we        <= w_we_d;
      r_ram_we    <= w_ram_we_d;
      r_ram_addr  <= w_ram_addr_d;
      r_ram_wdata <= w_ram_wdata_d;
      r_rdata     <= w_rdata_d;
      r_cnt       <= w_cnt_d;
      r_ptr       <= w_ptr_d;
      r_busy      <= (w_state_d != StIdle);
    end
  end

  assign o_gnt       = r_gnt;
  assign o_done      = r_done;
  assign o_rdata     = r_rdata;
  assign o_busy      = r_busy;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_we    = r_ram_we;
  assign o_ram_wdata = r_ram_wdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: drives a fixed-priority and a round-robin mem_arbiter
// (3 ports, RAM_LAT=2) with the same directed stimulus. Each has its own RAM.
// A transaction-level model predicts every output every cycle; directed
// literal checks pin the model on the key scenarios.
module tb_mem_arbiter;
  localparam int NP  = 3;
  localparam int DW  = 32;
  localparam int AW  = 16;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NP-1:0]    req = '0;
  logic [NP-1:0]    we = '0;
  logic [NP*AW-1:0] addr = '0;
  logic [NP*DW-1:0] wdata = '0;

  logic [NP-1:0] gnt_o [2];
  logic [NP-1:0] done_o [2];
  logic [DW-1:0] rdata_o [2];
  logic [DW-1:0] ram_wd_o [2];
  logic [DW-1:0] ram_rd [2];
  logic [AW-1:0] ram_addr_o [2];
  logic          busy_o [2];
  logic          ram_we_o [2];

  int checks = 0;
  int failures = 0;
  string dn [2] = '{"fix", "rr"};

  always #5 clk = ~clk;

  mem_arbiter #(.N_PORTS(NP), .DW(DW), .AW(AW), .RAM_LAT(LAT), .RR_MODE(0)) u_fix (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_gnt(gnt_o[0]), .o_done(done_o[0]), .o_rdata(rdata_o[0]), .o_busy(busy_o[0]),
    .o_ram_addr(ram_addr_o[0]), .o_ram_we(ram_we_o[0]), .o_ram_wdata(ram_wd_o[0]),
    .i_ram_rdata(ram_rd[0])
  );

  mem_arbiter #(.N_PORTS(NP), .DW(DW), .AW(AW), .RAM_LAT(LAT), .RR_MODE(1)) u_rr (
    .i_clk(clk), .i_reset(rst), .i_req(req), .i_we(we), .i_addr(addr), .i_wdata(wdata),
    .o_gnt(gnt_o[1]), .o_done(done_o[1]), .o_rdata(rdata_o[1]), .o_busy(busy_o[1]),
    .o_ram_addr(ram_addr_o[1]), .o_ram_we(ram_we_o[1]), .o_ram_wdata(ram_wd_o[1]),
    .i_ram_rdata(ram_rd[1])
  );

  // Default RAM contents: 0x10 holds DEADBEEF, everything else a tagged pattern.
  function automatic logic [31:0] dflt(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {16'hC0DE, 8'h00, a};
  endfunction

  // Bench RAMs (combinational read), written by the DUTs.
  logic [31:0] mem [2][256];
  bit          wr_v [2][256];
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ram_we_o[d]) begin
        mem[d][ram_addr_o[d][7:0]]  <= ram_wd_o[d];
        wr_v[d][ram_addr_o[d][7:0]] <= 1'b1;
      end
    end
  end
  always_comb begin
    for (int d = 0; d < 2; d++) begin
      ram_rd[d] = wr_v[d][ram_addr_o[d][7:0]] ? mem[d][ram_addr_o[d][7:0]]
                                               : dflt(ram_addr_o[d][7:0]);
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  // ---------------- transaction-level model ----------------
  logic [31:0] mmem [2][256];
  bit          mwv [2][256];
  bit          act [2];
  bit          fresh [2];
  int          g [2];
  int          w [2];
  int          ptr [2];
  logic        t_we [2];
  logic [15:0] t_addr [2];
  logic [31:0] t_wd [2];
  logic [31:0] e_rd [2];
  bit          started = 1'b0;
  int          cyc = 0;

  function automatic logic [31:0] mread(input int d, input logic [15:0] a);
    return mwv[d][a[7:0]] ? mmem[d][a[7:0]] : dflt(a[7:0]);
  endfunction

  function automatic int pick(input logic [NP-1:0] r, input int p, input bit rr);
    for (int i = 0; i < NP; i++) begin
      int j;
      j = rr ? (p + i) % NP : i;
      if (r[j]) return j;
    end
    return 0;
  endfunction

  // Model step at each edge, then compare all outputs just after it.
  initial begin : mon
    int k;
    logic [NP-1:0] oh;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (rst) begin
          act[d] = 1'b0; ptr[d] = 0; e_rd[d] = '0; fresh[d] = 1'b1;
        end else if (started) begin
          if (act[d] && (cyc - g[d] == LAT) && !t_we[d]) e_rd[d] = mread(d, t_addr[d]);
          // A new grant needs the previous one to be LAT+2 edges back.
          if ((!act[d] || cyc >= g[d] + LAT + 2) && req != '0) begin
            w[d]      = pick(req, ptr[d], d == 1);
            act[d]    = 1'b1;
            fresh[d]  = 1'b0;
            g[d]      = cyc;
            t_we[d]   = we[w[d]];
            t_addr[d] = addr[w[d]*AW +: AW];
            t_wd[d]   = wdata[w[d]*DW +: DW];
            ptr[d]    = (w[d] + 1) % NP;
            if (t_we[d]) begin
              mmem[d][t_addr[d][7:0]] = t_wd[d];
              mwv[d][t_addr[d][7:0]]  = 1'b1;
            end
          end
        end
      end
      if (rst) started = 1'b1;
      if (started) begin
        for (int d = 0; d < 2; d++) begin
          k  = cyc - g[d];
          oh = act[d] ? (NP'(1) << w[d]) : '0;
          chk({dn[d], "_gnt"},  gnt_o[d],  (act[d] && k == 0) ? oh : '0);
          chk({dn[d], "_done"}, done_o[d], (act[d] && k == LAT) ? oh : '0);
          chk({dn[d], "_busy"}, busy_o[d], act[d] && k <= LAT);
          chk({dn[d], "_ram_we"}, ram_we_o[d], act[d] && k == 0 && t_we[d]);
          chk({dn[d], "_rdata"}, rdata_o[d], e_rd[d]);
          if (act[d] && k < LAT) begin
            chk({dn[d], "_ram_addr"},  ram_addr_o[d], t_addr[d]);
            chk({dn[d], "_ram_wdata"}, ram_wd_o[d],   t_wd[d]);
          end else if (fresh[d]) begin
            chk({dn[d], "_ram_addr_rst"},  ram_addr_o[d], '0);
            chk({dn[d], "_ram_wdata_rst"}, ram_wd_o[d],   '0);
          end
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic setp(input int p, input bit r, input bit wr, input logic [15:0] a,
                      input logic [31:0] wd);
    req[p] = r;
    we[p]  = wr;
    addr[p*AW +: AW]  = a;
    wdata[p*DW +: DW] = wd;
  endtask

  logic [NP-1:0] fq[$];
  logic [NP-1:0] rq[$];
  int            ft[$];
  int            rt[$];
  logic [NP-1:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};

  initial begin
    nclk(3);
    chk("rst_gnt", gnt_o[0], 3'b000);
    chk("rst_busy", busy_o[1], 1'b0);
    chk("rst_rdata", rdata_o[0], 32'h0);
    rst = 1'b0;
    nclk(1);

    // Read: port0 @0x0010
    setp(0, 1'b1, 1'b0, 16'h0010, 32'h0);
    nclk(1);
    chk("rd_gnt_fix", gnt_o[0], 3'b001);
    chk("rd_gnt_rr", gnt_o[1], 3'b001);
    req = '0;
    nclk(2);
    chk("rd_done", done_o[0], 3'b001);
    chk("rd_data", rdata_o[0], 32'hDEADBEEF);
    chk("rd_data_rr", rdata_o[1], 32'hDEADBEEF);
    nclk(2);

    // Write: port1 writes 0x12345678 @0x0020
    setp(1, 1'b1, 1'b1, 16'h0020, 32'h12345678);
    nclk(1);
    chk("wr_gnt", gnt_o[0], 3'b010);
    chk("wr_we_on", ram_we_o[0], 1'b1);
    chk("wr_addr", ram_addr_o[0], 16'h0020);
    req = '0;
    we  = '0;
    nclk(1);
    chk("wr_we_off", ram_we_o[0], 1'b0);
    nclk(1);
    chk("wr_done", done_o[0], 3'b010);
    chk("wr_rdata_hold", rdata_o[0], 32'hDEADBEEF);
    nclk(2);

    // Read back via port2
    setp(2, 1'b1, 1'b0, 16'h0020, 32'h0);
    nclk(1);
    chk("rb_gnt", gnt_o[1], 3'b100);
    req = '0;
    nclk(2);
    chk("rb_data_fix", rdata_o[0], 32'h12345678);
    chk("rb_data_rr", rdata_o[1], 32'h12345678);
    nclk(2);

    // All ports request continuously
    setp(0, 1'b1, 1'b0, 16'h0010, 32'h0);
    setp(1, 1'b1, 1'b0, 16'h0020, 32'h0);
    setp(2, 1'b1, 1'b0, 16'h0030, 32'h0);
    for (int c = 0; c < 16; c++) begin
      nclk(1);
      if (gnt_o[0] != '0) begin fq.push_back(gnt_o[0]); ft.push_back(c); end
      if (gnt_o[1] != '0) begin rq.push_back(gnt_o[1]); rt.push_back(c); end
    end
    req = '0;
    chk("fix_ngrants", fq.size(), 4);
    chk("rr_ngrants", rq.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("fix_order", (i < fq.size()) ? fq[i] : 3'bxxx, 3'b001);
      chk("fix_time", (i < ft.size()) ? ft[i] : -1, 4 * i);
      chk("rr_order", (i < rq.size()) ? rq[i] : 3'bxxx, rr_exp[i]);
      chk("rr_time", (i < rt.size()) ? rt[i] : -1, 4 * i);
    end
    nclk(2);

    // Reset in the second ACCESS cycle
    setp(0, 1'b1, 1'b0, 16'h0010, 32'h0);
    nclk(1);
    chk("ra_gnt", gnt_o[0], 3'b001);
    req = '0;
    nclk(1);
    rst = 1'b1;
    setp(2, 1'b1, 1'b0, 16'h0030, 32'h0);
    nclk(1);
    for (int d = 0; d < 2; d++) begin
      chk("ra_done", done_o[d], 3'b000);
      chk("ra_busy", busy_o[d], 1'b0);
      chk("ra_gnt0", gnt_o[d], 3'b000);
      chk("ra_rdata", rdata_o[d], 32'h0);
      chk("ra_ram_we", ram_we_o[d], 1'b0);
      chk("ra_ram_addr", ram_addr_o[d], 16'h0);
    end
    rst = 1'b0;
    nclk(1);
    chk("ra_new_gnt_fix", gnt_o[0], 3'b100);
    chk("ra_new_gnt_rr", gnt_o[1], 3'b100);
    req = '0;
    nclk(4);

    // Address changes after grant
    setp(0, 1'b1, 1'b0, 16'h0010, 32'h0);
    nclk(1);
    chk("lc_gnt", gnt_o[0], 3'b001);
    chk("lc_addr0", ram_addr_o[0], 16'h0010);
    req = '0;
    addr[0 +: AW] = 16'h0099;
    nclk(1);
    chk("lc_addr1", ram_addr_o[0], 16'h0010);
    nclk(1);
    chk("lc_done", done_o[0], 3'b001);
    chk("lc_rdata", rdata_o[0], 32'hDEADBEEF);
    nclk(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule
